mult_serial_tx: RTL and testbench

- Transmit-side framer for the serial hardware multiplier. It takes a length field, a multiplier and a multiplicand in parallel and shifts out one fixed 32-bit serial frame: 8 length bits, then L multiplier bits, then (24-L) multiplicand bits.
- It drives the frame-start strobe and the per-bit field flags that the multiplier's receive sequencer consumes.
- It sits between the operand source (host/register bank) and the serial multiplier datapath.

---
 rtl/mult_serial_tx.sv | 167 ++++++++++++++++
 tb/tb_mult_serial_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mult_serial_tx.sv
// Serial frame transmitter: {length, multiplier[L-1:0], multiplicand[23-L:0]}, MSB-first per field.
// Latency: accept edge -> strobe (1) -> 32 bit cycles -> done (1); start is ignored while busy.
module mult_serial_tx #(
  parameter int FRAME_BITS = 32,
  parameter int LEN_BITS   = 8,
  parameter int OP_BITS    = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [LEN_BITS-1:0]         mult_length,
  input  logic [OP_BITS-1:0]          multiplier,
  input  logic [OP_BITS-1:0]          multiplicand,
  output logic                        ready,
  output logic                        ctrl,
  output logic                        sdata,
  output logic                        length_bit,
  output logic                        multiplier_bit,
  output logic                        multiplicand_bit,
  output logic [$clog2(FRAME_BITS):0] shift_count,
  output logic                        done,
  output logic                        err
);

  localparam int CW = $clog2(OP_BITS);
  localparam int LW = $clog2(LEN_BITS);
  localparam int SW = $clog2(FRAME_BITS) + 1;
  localparam logic [LEN_BITS-1:0] OP_LEN  = LEN_BITS'(OP_BITS);
  localparam logic [CW-1:0]       LEN_TOP = CW'(LEN_BITS - 1);
  localparam logic [CW-1:0]       OP_TOP  = CW'(OP_BITS - 1);

  typedef enum logic [5:0] {
    IDLE     = 6'b000001,
    STROBE   = 6'b000010,
    LEN_ST   = 6'b000100,
    MULT1_ST = 6'b001000,
    MULT2_ST = 6'b010000,
    FIN      = 6'b100000
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LEN_BITS-1:0]   len_q;
  logic [OP_BITS-1:0]    mplier_q, mcand_q;
  logic                  accept, reject;
  logic                  bit_q, bit_d;
  logic                  sdata_d;
  logic [SW-1:0]         sc_d;

  // cnt counts down the MSB-first bit index within the current field
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (mult_length > OP_LEN) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = STROBE;
          end
        end
      end
      STROBE: begin
        state_d = LEN_ST;
        cnt_d   = LEN_TOP;
      end
      LEN_ST: begin
        if (cnt_q == '0) begin
          if (len_q == '0) begin
            state_d = MULT2_ST;
            cnt_d   = OP_TOP;
          end else begin
            state_d = MULT1_ST;
            cnt_d   = CW'(len_q - LEN_BITS'(1));
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      MULT1_ST: begin
        if (cnt_q == '0) begin
          if (len_q == OP_LEN) begin
            state_d = FIN;
          end else begin
            state_d = MULT2_ST;
            cnt_d   = OP_TOP - CW'(len_q);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      MULT2_ST: begin
        if (cnt_q == '0) begin
          state_d = FIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they can all be registered
  always_comb begin
    bit_q   = (state_q == LEN_ST) || (state_q == MULT1_ST) || (state_q == MULT2_ST);
    bit_d   = (state_d == LEN_ST) || (state_d == MULT1_ST) || (state_d == MULT2_ST);
    sdata_d = 1'b0;
    case (state_d)
      LEN_ST:   sdata_d = len_q[cnt_d[LW-1:0]];
      MULT1_ST: sdata_d = mplier_q[cnt_d];
      MULT2_ST: sdata_d = mcand_q[cnt_d];
      default:  sdata_d = 1'b0;
    endcase
    sc_d = '0;
    if (bit_d && bit_q) begin
      sc_d = shift_count + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        len_q    <= mult_length;
        mplier_q <= multiplier;
        mcand_q  <= multiplicand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready            <= 1'b1;
      ctrl             <= 1'b0;
      sdata            <= 1'b0;
      length_bit       <= 1'b0;
      multiplier_bit   <= 1'b0;
      multiplicand_bit <= 1'b0;
      shift_count      <= '0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      ready            <= (state_d == IDLE);
      ctrl             <= (state_d == STROBE);
      sdata            <= sdata_d;
      length_bit       <= (state_d == LEN_ST);
      multiplier_bit   <= (state_d == MULT1_ST);
      multiplicand_bit <= (state_d == MULT2_ST);
      shift_count      <= sc_d;
      done             <= (state_d == FIN);
      err              <= reject;
    end
  end

endmodule

// File: tb/tb_mult_serial_tx.sv
// Directed bench for mult_serial_tx: reset, frame content per length, reject, busy and async abort.
module tb_mult_serial_tx;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  mult_length;
  logic [23:0] multiplier;
  logic [23:0] multiplicand;
  logic        ready, ctrl, sdata;
  logic        length_bit, multiplier_bit, multiplicand_bit;
  logic [5:0]  shift_count;
  logic        done, err;

  int n_tests = 0;
  int n_fail  = 0;

  // {ready, ctrl, sdata, length_bit, multiplier_bit, multiplicand_bit, shift_count, done, err}
  logic [13:0] obs_all;
  assign obs_all = {ready, ctrl, sdata, length_bit, multiplier_bit, multiplicand_bit,
                    shift_count, done, err};

  localparam logic [13:0] V_IDLE   = 14'h2000;
  localparam logic [13:0] V_REJ    = 14'h2001;
  localparam logic [13:0] V_STROBE = 14'h1000;
  localparam logic [13:0] V_FIN    = 14'h0002;

  mult_serial_tx dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .mult_length      (mult_length),
    .multiplier       (multiplier),
    .multiplicand     (multiplicand),
    .ready            (ready),
    .ctrl             (ctrl),
    .sdata            (sdata),
    .length_bit       (length_bit),
    .multiplier_bit   (multiplier_bit),
    .multiplicand_bit (multiplicand_bit),
    .shift_count      (shift_count),
    .done             (done),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Sends one frame and checks strobe, every bit cycle, done and return to idle.
  task automatic run_frame(input string tag, input logic [7:0] l, input logic [23:0] mp,
                           input logic [23:0] mc, input logic [31:0] exp_frame, input bit poke);
    logic [31:0] obs;
    logic [2:0]  exp_flags;
    int n_len, n_m1, n_m2, bad_flag, bad_sc, bad_misc;
    obs = '0;
    n_len = 0; n_m1 = 0; n_m2 = 0; bad_flag = 0; bad_sc = 0; bad_misc = 0;
    @(negedge clk);
    start = 1'b1; mult_length = l; multiplier = mp; multiplicand = mc;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":strobe"}, 32'(obs_all), 32'(V_STROBE));
    if (poke) begin
      start = 1'b1; mult_length = 8'd3; multiplier = ~mp; multiplicand = ~mc;
    end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      obs = {obs[30:0], sdata};
      if (k < 8)                exp_flags = 3'b100;
      else if (k < 8 + int'(l)) exp_flags = 3'b010;
      else                      exp_flags = 3'b001;
      if ({length_bit, multiplier_bit, multiplicand_bit} != exp_flags) bad_flag++;
      if (shift_count != 6'(k)) bad_sc++;
      if (ctrl || done || err || ready) bad_misc++;
      if (length_bit)       n_len++;
      if (multiplier_bit)   n_m1++;
      if (multiplicand_bit) n_m2++;
      if (poke) begin
        start        = k[0];
        mult_length  = 8'($urandom_range(0, 30));
        multiplier   = 24'($urandom);
        multiplicand = 24'($urandom);
      end
    end
    start = 1'b0;
    chk({tag, ":frame"}, obs, exp_frame);
    chk({tag, ":flag_seq"}, 32'(bad_flag), 32'd0);
    chk({tag, ":shift_count"}, 32'(bad_sc), 32'd0);
    chk({tag, ":quiet_in_frame"}, 32'(bad_misc), 32'd0);
    chk({tag, ":n_len"}, 32'(n_len), 32'd8);
    chk({tag, ":n_mult"}, 32'(n_m1), 32'(l));
    chk({tag, ":n_mcand"}, 32'(n_m2), 32'(24 - int'(l)));
    @(negedge clk);
    chk({tag, ":fin"}, 32'(obs_all), 32'(V_FIN));
    @(negedge clk);
    chk({tag, ":idle"}, 32'(obs_all), 32'(V_IDLE));
  endtask

  task automatic run_reject(input string tag, input logic [7:0] l);
    @(negedge clk);
    start = 1'b1; mult_length = l; multiplier = 24'h123456; multiplicand = 24'h654321;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":err_pulse"}, 32'(obs_all), 32'(V_REJ));
    @(negedge clk);
    chk({tag, ":after"}, 32'(obs_all), 32'(V_IDLE));
  endtask

  initial begin
    bit found;
    rst = 1'b0; start = 1'b1;
    mult_length = 8'd8; multiplier = 24'h0000A5; multiplicand = 24'h00C3F0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", 32'(obs_all), 32'(V_IDLE));
    end
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    chk("reset_release", 32'(obs_all), 32'(V_IDLE));

    run_frame("nominal", 8'd8,  24'h0000A5, 24'h00C3F0, 32'h08A5C3F0, 1'b0);
    run_frame("len0",    8'd0,  24'h5A5A5A, 24'hFFFFFF, 32'h00FFFFFF, 1'b0);
    run_frame("len24",   8'd24, 24'h800001, 24'h123456, 32'h18800001, 1'b0);
    run_frame("len5",    8'd5,  24'hFFFFF5, 24'hABCDEF, 32'h05ABCDEF, 1'b0);

    run_reject("rej25", 8'd25);
    run_reject("rejff", 8'hFF);

    run_frame("busy", 8'd5, 24'hFFFFF5, 24'hABCDEF, 32'h05ABCDEF, 1'b1);

    @(negedge clk);
    start = 1'b1; mult_length = 8'd8; multiplier = 24'h0000A5; multiplicand = 24'h00C3F0;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (shift_count == 6'd12) found = 1'b1;
    end
    chk("abort_reach12", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_async_clear", 32'(obs_all), 32'(V_IDLE));
    @(negedge clk);
    chk("abort_hold", 32'(obs_all), 32'(V_IDLE));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_release", 32'(obs_all), 32'(V_IDLE));

    run_frame("post_abort", 8'd8, 24'h0000A5, 24'h00C3F0, 32'h08A5C3F0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
